// File: rtl/lc3b_ctrl_sequencer_pkg.sv
// lc3b_ctrl_sequencer_pkg: LC-3b opcodes, control word, mux selects, sequencer states and the decode function
package lc3b_ctrl_sequencer_pkg;
  typedef enum logic [3:0] {
    op_br, op_add, op_ldb, op_stb, op_jsr, op_and, op_ldr, op_str,
    op_rti, op_not, op_ldi, op_sti, op_jmp, op_shf, op_lea, op_trap
  } lc3b_opcode;
  typedef enum logic [2:0] {alu_add, alu_and, alu_not, alu_pass, alu_sll, alu_srl, alu_sra} lc3b_aluop;
  localparam logic [2:0] ALUMUX_SR2 = 3'b000;
  localparam logic [2:0] ALUMUX_ADJ6 = 3'b001;
  localparam logic [2:0] ALUMUX_IMM4 = 3'b010;
  localparam logic [2:0] ALUMUX_SEXT5 = 3'b011;
  localparam logic [2:0] ALUMUX_TRAPVEC = 3'b100;
  localparam logic [2:0] ALUMUX_SEXT6 = 3'b101;
  localparam logic [2:0] REGMUX_ALU = 3'b000;
  localparam logic [2:0] REGMUX_MEM = 3'b001;
  localparam logic [2:0] REGMUX_PC = 3'b010;
  localparam logic [2:0] REGMUX_MEMB = 3'b011;
  localparam logic [2:0] REGMUX_LEA = 3'b100;
  localparam logic [1:0] PCMUX_PC2 = 2'b00;
  localparam logic [1:0] PCMUX_OFF = 2'b01;
  localparam logic [1:0] PCMUX_REG = 2'b10;
  localparam logic [1:0] PCMUX_MEM = 2'b11;
  typedef logic [1:0] seq_state_t;
  localparam seq_state_t S_RUN = 2'd0;
  localparam seq_state_t S_IND = 2'd1;
  localparam seq_state_t S_ERR = 2'd2;
  typedef struct packed {
    lc3b_opcode opcode;
    lc3b_aluop aluop;
    logic [2:0] alumux_sel;
    logic [2:0] regfilemux_sel;
    logic [1:0] pcmux_sel;
    logic storemux_sel;
    logic mem_read;
    logic mem_write;
    logic load_regfile;
    logic load_cc;
    logic load_pc;
    logic load_ifid;
    logic load_idex;
    logic load_exmem;
  } lc3b_control_word;
  // Indirect ops share the base+offset datapath of LDR/STR; the sequencer adds the second access.
  function automatic lc3b_control_word lc3b_decode(input lc3b_opcode op, input logic bit11,
                                                   input logic bit5, input logic bit4);
    lc3b_control_word c;
    c = '0;
    c.opcode = op;
    c.aluop = alu_pass;
    case (op)
      op_br: c.pcmux_sel = PCMUX_OFF;
      op_add, op_and: begin
        c.aluop = op == op_add ? alu_add : alu_and;
        c.alumux_sel = bit5 ? ALUMUX_SEXT5 : ALUMUX_SR2;
        c.load_regfile = 1'b1;
        c.load_cc = 1'b1;
      end
      op_not: begin
        c.aluop = alu_not;
        c.load_regfile = 1'b1;
        c.load_cc = 1'b1;
      end
      op_shf: begin
        c.aluop = !bit4 ? alu_sll : bit5 ? alu_sra : alu_srl;
        c.alumux_sel = ALUMUX_IMM4;
        c.load_regfile = 1'b1;
        c.load_cc = 1'b1;
      end
      op_ldr, op_ldi, op_ldb: begin
        c.aluop = alu_add;
        c.alumux_sel = op == op_ldb ? ALUMUX_SEXT6 : ALUMUX_ADJ6;
        c.regfilemux_sel = op == op_ldb ? REGMUX_MEMB : REGMUX_MEM;
        c.mem_read = 1'b1;
        c.load_regfile = 1'b1;
        c.load_cc = 1'b1;
      end
      op_str, op_sti, op_stb: begin
        c.aluop = alu_add;
        c.alumux_sel = op == op_stb ? ALUMUX_SEXT6 : ALUMUX_ADJ6;
        c.storemux_sel = 1'b1;
        c.mem_write = 1'b1;
      end
      op_jsr: begin
        c.pcmux_sel = bit11 ? PCMUX_OFF : PCMUX_REG;
        c.regfilemux_sel = REGMUX_PC;
        c.load_regfile = 1'b1;
      end
      op_jmp: c.pcmux_sel = PCMUX_REG;
      op_lea: begin
        c.regfilemux_sel = REGMUX_LEA;
        c.load_regfile = 1'b1;
        c.load_cc = 1'b1;
      end
      op_trap: begin
        c.alumux_sel = ALUMUX_TRAPVEC;
        c.regfilemux_sel = REGMUX_PC;
        c.pcmux_sel = PCMUX_MEM;
        c.mem_read = 1'b1;
        c.load_regfile = 1'b1;
      end
      default: c.pcmux_sel = PCMUX_PC2;
    endcase
    return c;
  endfunction
endpackage

// File: rtl/lc3b_ctrl_sequencer_decode.sv
// lc3b_ctrl_decode: combinational ID-stage decode into an lc3b_control_word
module lc3b_ctrl_decode
  import lc3b_ctrl_sequencer_pkg::*;
(
  input  logic [3:0]       opcode,
  input  logic             bit11,
  input  logic             bit5,
  input  logic             bit4,
  output lc3b_control_word ctrl
);
  assign ctrl = lc3b_decode(lc3b_opcode'(opcode), bit11, bit5, bit4);
endmodule

// File: rtl/lc3b_ctrl_sequencer.sv
// lc3b_ctrl_sequencer: ID-stage decode plus MEM-stage D-mem sequencer with indirect ops, watchdog and stall counter
module lc3b_ctrl_sequencer
  import lc3b_ctrl_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 256,
  parameter int TMO_W = 9,
  parameter int STALL_CNT_W = 16,
  parameter int INDIRECT_EN = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [3:0]             opcode,
  input  logic                   bit11,
  input  logic                   bit5,
  input  logic                   bit4,
  output lc3b_control_word       ctrl,
  input  logic                   mem_valid,
  input  logic [3:0]             mem_opcode,
  input  logic                   dmem_resp,
  input  logic [15:0]            dmem_rdata,
  output logic                   dmem_read,
  output logic                   dmem_write,
  output logic                   addr_sel,
  output logic [15:0]            ptr_q,
  output logic                   stall,
  output logic                   err,
  output logic [STALL_CNT_W-1:0] stall_cnt
);
  localparam logic IND_EN = 1'(INDIRECT_EN != 0);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  lc3b_control_word dec;
  lc3b_opcode mop;
  seq_state_t state, state_d;
  logic [TMO_W-1:0] tmo;
  logic ind_wr, acc_op, rd_op, ind_op, strobe, timeout;
  lc3b_ctrl_decode u_dec (.opcode(opcode), .bit11(bit11), .bit5(bit5), .bit4(bit4), .ctrl(dec));
  always_comb begin
    ctrl = dec;
    ctrl.load_pc = ~stall;
    ctrl.load_ifid = ~stall;
    ctrl.load_idex = ~stall;
    ctrl.load_exmem = ~stall;
  end
  assign mop = lc3b_opcode'(mem_opcode);
  assign acc_op = mem_valid & (mop inside {op_ldr, op_ldb, op_ldi, op_str, op_stb, op_sti, op_trap});
  assign ind_op = IND_EN & (mop == op_ldi | mop == op_sti);
  // The first access of an indirect store fetches the pointer, so it is a read.
  assign rd_op = acc_op & ~(mop == op_str | mop == op_stb | (mop == op_sti & ~IND_EN));
  // Outputs are forced low while reset is asserted so nothing strobes during reset.
  assign dmem_read = reset_n & (state == S_RUN ? rd_op : state == S_IND & ~ind_wr);
  assign dmem_write = reset_n & (state == S_RUN ? acc_op & ~rd_op : state == S_IND & ind_wr);
  assign addr_sel = reset_n & state == S_IND;
  assign stall = reset_n & (state == S_ERR | (state == S_IND & ~dmem_resp) |
                            (state == S_RUN & acc_op & (~dmem_resp | ind_op)));
  assign err = state == S_ERR;
  assign strobe = dmem_read | dmem_write;
  assign timeout = (TIMEOUT != 0) & strobe & ~dmem_resp & tmo == TMO_LAST;
  assign state_d = timeout ? S_ERR :
                   state == S_RUN & acc_op & ind_op & dmem_resp ? S_IND :
                   state == S_IND & dmem_resp ? S_RUN : state;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_RUN;
      ptr_q <= '0;
      tmo <= '0;
      ind_wr <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state <= state_d;
      tmo <= (dmem_resp | ~strobe | state_d != state) ? '0 : tmo + 1'b1;
      if (state == S_RUN & state_d == S_IND) begin
        ptr_q <= dmem_rdata;
        ind_wr <= mop == op_sti;
      end
      if (stall & ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_lc3b_ctrl_sequencer.sv
// tb_lc3b_ctrl_sequencer: randomized transaction-level checks of decode and D-mem sequencing
module tb_lc3b_ctrl_sequencer;
  import lc3b_ctrl_sequencer_pkg::*;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [3:0] opcode = '0, mem_opcode = '0;
  logic bit11 = 1'b0, bit5 = 1'b0, bit4 = 1'b0, mem_valid = 1'b0, dmem_resp = 1'b0;
  logic [15:0] dmem_rdata = '0, ptr_q;
  lc3b_control_word ctrl;
  logic dmem_read, dmem_write, addr_sel, stall, err;
  logic [3:0] stall_cnt;
  logic [15:0] acc_mask = 16'h8CCC, rf_mask = 16'hE676, rd_mask = 16'h8444, wr_mask = 16'h0888;
  int n_tests = 0, n_fail = 0, model_stalls = 0;
  lc3b_ctrl_sequencer #(.TIMEOUT(4), .TMO_W(3), .STALL_CNT_W(4), .INDIRECT_EN(1)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .bit11(bit11), .bit5(bit5), .bit4(bit4),
    .ctrl(ctrl), .mem_valid(mem_valid), .mem_opcode(mem_opcode), .dmem_resp(dmem_resp),
    .dmem_rdata(dmem_rdata), .dmem_read(dmem_read), .dmem_write(dmem_write), .addr_sel(addr_sel),
    .ptr_q(ptr_q), .stall(stall), .err(err), .stall_cnt(stall_cnt));
  always #5 clk = ~clk;
  function automatic int sat(input int v);
    return v > 15 ? 15 : v;
  endfunction
  task automatic do_reset();
    mem_valid = 1'b0;
    dmem_resp = 1'b0;
    reset_n = 1'b0;
    model_stalls = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask
  // One MEM-stage instruction: the bench answers each access after w cycles of waiting.
  task automatic run_op(input logic vld, input logic [3:0] op, input int w1, input int w2,
                        input logic [15:0] rd);
    logic ind, er, esel, last;
    int na, w;
    ind = vld && (op == 4'd10 || op == 4'd11);
    na = !(vld && acc_mask[op]) ? 0 : ind ? 2 : 1;
    mem_valid = vld;
    mem_opcode = op;
    if (na == 0) begin
      dmem_resp = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_tests++;
      if ({dmem_read, dmem_write, addr_sel, stall} !== 4'b0000) begin
        n_fail++;
        $display("FAIL idle_op op=%0d got rd/wr/sel/stall=%b want 0000", op, {dmem_read, dmem_write, addr_sel, stall});
      end
      @(posedge clk);
      #1;
    end
    for (int a = 0; a < na; a++) begin
      w = a == 0 ? w1 : w2;
      er = a == 0 ? !(op == 4'd7 || op == 4'd3) : op == 4'd10;
      esel = a == 1;
      for (int c = 0; c <= w; c++) begin
        last = a == na - 1 && c == w;
        dmem_resp = c == w;
        dmem_rdata = (c == w && a == 0) ? rd : 16'($urandom);
        @(negedge clk);
        n_tests++;
        if ({dmem_read, dmem_write, addr_sel, stall, ctrl.load_pc} !== {er, !er, esel, !last, last}) begin
          n_fail++;
          $display("FAIL access op=%0d acc=%0d cyc=%0d got rd/wr/sel/stall/ldpc=%b want %b", op, a, c,
                   {dmem_read, dmem_write, addr_sel, stall, ctrl.load_pc}, {er, !er, esel, !last, last});
        end
        if (!last) model_stalls++;
        @(posedge clk);
        #1;
      end
    end
    mem_valid = 1'b0;
    dmem_resp = 1'b0;
    if (ind) begin
      n_tests++;
      if (ptr_q !== rd) begin
        n_fail++;
        $display("FAIL ptr_q op=%0d got %h want %h", op, ptr_q, rd);
      end
    end
    n_tests++;
    if (stall_cnt !== 4'(sat(model_stalls))) begin
      n_fail++;
      $display("FAIL stall_cnt op=%0d got %0d want %0d", op, stall_cnt, sat(model_stalls));
    end
  endtask
  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({dmem_read, dmem_write, addr_sel, stall, err, ptr_q, stall_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_state got %b/%b/%b/%b/%b ptr=%h cnt=%0d want all zero",
               dmem_read, dmem_write, addr_sel, stall, err, ptr_q, stall_cnt);
    end
    do_reset();
  endtask
  task automatic test_decode();
    opcode = 4'd1;
    bit5 = 1'b1;
    @(negedge clk);
    n_tests++;
    if (ctrl.alumux_sel !== 3'b011 || ctrl.aluop !== alu_add || ctrl.load_regfile !== 1'b1 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL add_imm got alumux=%b aluop=%0d ldrf=%b stall=%b want 011/%0d/1/0",
               ctrl.alumux_sel, ctrl.aluop, ctrl.load_regfile, stall, alu_add);
    end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      opcode = 4'($urandom_range(0, 15));
      {bit11, bit5, bit4} = 3'($urandom);
      @(negedge clk);
      n_tests++;
      if ({ctrl.load_regfile, ctrl.mem_read, ctrl.mem_write, ctrl.load_ifid} !==
          {rf_mask[opcode], rd_mask[opcode], wr_mask[opcode], 1'b1}) begin
        n_fail++;
        $display("FAIL decode_flags op=%0d got %b want %b", opcode,
                 {ctrl.load_regfile, ctrl.mem_read, ctrl.mem_write, ctrl.load_ifid},
                 {rf_mask[opcode], rd_mask[opcode], wr_mask[opcode], 1'b1});
      end
      if (opcode == 4'd1 || opcode == 4'd5) begin
        n_tests++;
        if (ctrl.alumux_sel !== (bit5 ? 3'b011 : 3'b000) || ctrl.aluop !== (opcode == 4'd1 ? alu_add : alu_and)) begin
          n_fail++;
          $display("FAIL decode_alu op=%0d bit5=%b got alumux=%b aluop=%0d", opcode, bit5, ctrl.alumux_sel, ctrl.aluop);
        end
      end
      if (opcode == 4'd6 || opcode == 4'd10) begin
        n_tests++;
        if (ctrl.regfilemux_sel !== REGMUX_MEM || ctrl.alumux_sel !== ALUMUX_ADJ6 || ctrl.load_cc !== 1'b1) begin
          n_fail++;
          $display("FAIL decode_load op=%0d got regmux=%b alumux=%b cc=%b", opcode, ctrl.regfilemux_sel, ctrl.alumux_sel, ctrl.load_cc);
        end
      end
      if (opcode == 4'd7 || opcode == 4'd11) begin
        n_tests++;
        if (ctrl.storemux_sel !== 1'b1) begin
          n_fail++;
          $display("FAIL decode_store op=%0d got storemux=%b want 1", opcode, ctrl.storemux_sel);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic test_directed();
    run_op(1'b1, 4'd6, 0, 0, 16'h0);
    run_op(1'b1, 4'd10, 2, 2, 16'h3000);
    n_tests++;
    if (model_stalls != 5 || stall_cnt !== 4'd5) begin
      n_fail++;
      $display("FAIL ldi_stalls got %0d want 5", stall_cnt);
    end
    do_reset();
    run_op(1'b1, 4'd11, 1, 2, 16'h4abc);
  endtask
  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 40; i++)
      run_op(1'($urandom_range(0, 4) != 0), 4'($urandom_range(0, 15)), $urandom_range(0, 3),
             $urandom_range(0, 3), 16'($urandom));
  endtask
  task automatic test_timeout();
    do_reset();
    mem_valid = 1'b1;
    mem_opcode = 4'd6;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_tests++;
      if ({dmem_read, stall, err} !== 3'b110) begin
        n_fail++;
        $display("FAIL tmo_wait cyc=%0d got rd/stall/err=%b want 110", c, {dmem_read, stall, err});
      end
      model_stalls++;
      @(posedge clk);
      #1;
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_tests++;
      if ({dmem_read, dmem_write, stall, err} !== 4'b0011) begin
        n_fail++;
        $display("FAIL tmo_err cyc=%0d got rd/wr/stall/err=%b want 0011", c, {dmem_read, dmem_write, stall, err});
      end
      model_stalls++;
      @(posedge clk);
      #1;
    end
    n_tests++;
    if (stall_cnt !== 4'(sat(model_stalls))) begin
      n_fail++;
      $display("FAIL stall_sat got %0d want %0d", stall_cnt, sat(model_stalls));
    end
  endtask
  task automatic test_reset_mid_ind();
    do_reset();
    mem_valid = 1'b1;
    mem_opcode = 4'd10;
    dmem_resp = 1'b1;
    dmem_rdata = 16'h5a5a;
    @(posedge clk);
    #1;
    dmem_resp = 1'b0;
    n_tests++;
    if (addr_sel !== 1'b1 || dmem_read !== 1'b1) begin
      n_fail++;
      $display("FAIL ind_entry got sel=%b rd=%b want 1/1", addr_sel, dmem_read);
    end
    mem_valid = 1'b0;
    reset_n = 1'b0;
    model_stalls = 0;
    #1;
    n_tests++;
    if ({dmem_read, dmem_write, addr_sel, stall, err, ptr_q, stall_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid got %b/%b/%b/%b/%b ptr=%h cnt=%0d want all zero",
               dmem_read, dmem_write, addr_sel, stall, err, ptr_q, stall_cnt);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    n_tests++;
    if ({dmem_read, dmem_write, addr_sel, stall} !== 4'b0000) begin
      n_fail++;
      $display("FAIL after_release got %b want 0000", {dmem_read, dmem_write, addr_sel, stall});
    end
    @(posedge clk);
    #1;
    run_op(1'b1, 4'd6, 1, 0, 16'h0);
  endtask
  initial begin
    test_reset();
    test_decode();
    test_directed();
    test_back_to_back();
    test_timeout();
    test_reset_mid_ind();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
